// File: rtl/serial_vec.sv
// serial_vec: captures a CORE-wide signed vector on a write strobe
// and replays it one word per clock, lowest index first.
module serial_vec #(
  parameter int DWIDTH = 16,
  parameter int LWIDTH = 10,
  parameter int CORE   = 8
) (
  input  logic                     clk,
  input  logic                     xrst,
  input  logic                     serial_we,
  input  logic signed [DWIDTH-1:0] in_data [CORE-1:0],
  output logic signed [DWIDTH-1:0] out_data
);

  localparam int IW = (CORE > 1) ? $clog2(CORE) : 1;
  localparam logic [LWIDTH-1:0] CORE_L = LWIDTH'(CORE);
  localparam logic [LWIDTH-1:0] ONE    = LWIDTH'(1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t                   state, state_n;
  logic [LWIDTH-1:0]        idx, idx_n;
  logic signed [DWIDTH-1:0] out_n;
  logic signed [DWIDTH-1:0] buffer [CORE-1:0];
  logic                     shift_go;
  logic                     drain_go;

  assign shift_go = !serial_we && state == SHIFT
                    && idx < CORE_L;
  assign drain_go = !serial_we && state == SHIFT
                    && idx >= CORE_L;

  always_comb begin
    state_n = state;
    idx_n   = idx;
    out_n   = out_data;
    unique case (1'b1)
      serial_we: begin
        state_n = SHIFT;
        idx_n   = ONE;
        out_n   = in_data[0];
      end
      shift_go: begin
        idx_n = idx + ONE;
        out_n = buffer[idx[IW-1:0]];
      end
      drain_go: begin
        state_n = IDLE;
        idx_n   = '0;
        out_n   = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      state    <= IDLE;
      idx      <= '0;
      out_data <= '0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      out_data <= out_n;
    end
  end

  // Buffer is written only on a strobe; it keeps old words while idle.
  always_ff @(posedge clk or negedge xrst) begin
    if (!xrst) begin
      for (int i = 0; i < CORE; i++)
        buffer[i] <= '0;
    end else if (serial_we) begin
      for (int i = 0; i < CORE; i++)
        buffer[i] <= in_data[i];
    end
  end

endmodule

// File: tb/tb_serial_vec.sv
// tb_serial_vec: directed checks of the serial_vec
// parallel-to-serial converter.
module tb_serial_vec;

  localparam int DW = 16;
  localparam int CORE = 8;

  logic                 clk = 1'b0;
  logic                 xrst = 1'b0;
  logic                 serial_we = 1'b0;
  logic signed [DW-1:0] in_data [CORE-1:0];
  logic signed [DW-1:0] out_data;

  int compared = 0;
  int mismatched = 0;

  logic signed [DW-1:0] sv [CORE-1:0];

  serial_vec #(
    .DWIDTH(DW),
    .LWIDTH(10),
    .CORE  (CORE)
  ) dut (
    .clk      (clk),
    .xrst     (xrst),
    .serial_we(serial_we),
    .in_data  (in_data),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic signed [DW-1:0] exp);
    compared++;
    assert (out_data === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, out_data, exp);
    end
  endtask

  task automatic load_ramp(input int base);
    for (int i = 0; i < CORE; i++)
      in_data[i] = DW'(base + i);
  endtask

  initial begin
    sv[0] = -16'sd1;
    sv[1] = -16'sd32768;
    sv[2] = 16'sd32767;
    sv[3] = 16'sd5;
    sv[4] = -16'sd5;
    sv[5] = 16'sd0;
    sv[6] = 16'sd1;
    sv[7] = -16'sd2;
    load_ramp(0);

    // reset
    #3;
    chk("rst_async", 16'sd0);
    step();
    chk("rst_hold", 16'sd0);
    xrst = 1'b1;
    step();
    chk("idle0", 16'sd0);
    step();
    chk("idle1", 16'sd0);

    // basic ramp 0..7
    load_ramp(0);
    serial_we = 1'b1;
    step();
    serial_we = 1'b0;
    chk("basic_w0", 16'sd0);
    for (int k = 1; k < CORE; k++) begin
      step();
      chk($sformatf("basic_w%0d", k), DW'(k));
    end
    step();
    chk("basic_drain", 16'sd0);
    step();
    chk("basic_idle", 16'sd0);

    // signed vector, input changed after strobe
    for (int i = 0; i < CORE; i++)
      in_data[i] = sv[i];
    serial_we = 1'b1;
    step();
    serial_we = 1'b0;
    for (int i = 0; i < CORE; i++)
      in_data[i] = 16'sh1234;
    chk("sgn_w0", -16'sd1);
    step();
    chk("sgn_w1", -16'sd32768);
    step();
    chk("sgn_w2", 16'sd32767);
    step();
    chk("sgn_w3", 16'sd5);
    step();
    chk("sgn_w4", -16'sd5);
    step();
    chk("sgn_w5", 16'sd0);
    step();
    chk("sgn_w6", 16'sd1);
    step();
    chk("sgn_w7", -16'sd2);
    step();
    chk("sgn_drain", 16'sd0);

    // restart at E+3
    load_ramp(0);
    serial_we = 1'b1;
    step();
    serial_we = 1'b0;
    chk("rs_a0", 16'sd0);
    step();
    chk("rs_a1", 16'sd1);
    step();
    chk("rs_a2", 16'sd2);
    load_ramp(10);
    serial_we = 1'b1;
    step();
    serial_we = 1'b0;
    chk("rs_b0", 16'sd10);
    for (int k = 1; k < CORE; k++) begin
      step();
      chk($sformatf("rs_b%0d", k), DW'(10 + k));
    end
    step();
    chk("rs_drain", 16'sd0);

    // mid-stream reset at E+4
    load_ramp(20);
    serial_we = 1'b1;
    step();
    serial_we = 1'b0;
    chk("mr_w0", 16'sd20);
    for (int k = 1; k < 4; k++) begin
      step();
      chk($sformatf("mr_w%0d", k), DW'(20 + k));
    end
    #2;
    xrst = 1'b0;
    #1;
    chk("mr_async", 16'sd0);
    step();
    chk("mr_hold", 16'sd0);
    #2;
    xrst = 1'b1;
    step();
    chk("mr_idle0", 16'sd0);
    step();
    chk("mr_idle1", 16'sd0);
    load_ramp(30);
    serial_we = 1'b1;
    step();
    serial_we = 1'b0;
    chk("mr_n0", 16'sd30);
    for (int k = 1; k < CORE; k++) begin
      step();
      chk($sformatf("mr_n%0d", k), DW'(30 + k));
    end

    // gapless: strobe exactly at E+CORE
    load_ramp(40);
    serial_we = 1'b1;
    step();
    serial_we = 1'b0;
    chk("gl_a0", 16'sd40);
    for (int k = 1; k < CORE; k++) begin
      step();
      chk($sformatf("gl_a%0d", k), DW'(40 + k));
    end
    load_ramp(-50);
    serial_we = 1'b1;
    step();
    serial_we = 1'b0;
    chk("gl_b0", -16'sd50);
    step();
    chk("gl_b1", -16'sd49);
    for (int k = 2; k < CORE; k++) step();
    chk("gl_b7", -16'sd43);
    step();
    chk("gl_drain", 16'sd0);

    // strobe held: reload every cycle
    serial_we = 1'b1;
    load_ramp(100);
    step();
    chk("hold0", 16'sd100);
    load_ramp(200);
    step();
    chk("hold1", 16'sd200);
    load_ramp(-300);
    step();
    chk("hold2", -16'sd300);
    serial_we = 1'b0;
    step();
    chk("hold_w1", -16'sd299);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
